// File: rtl/spike_fifo_reader_pkg.sv
// Shared definitions for the spike FIFO drain path and the router-side AER receiver.
//   NUM_CH_DEF / ADDR_DW_DEF / STAMP_DW_DEF : default bank geometry
//   EVT_CNT_W                               : width of the completed-event counter
//   aer_fsm_e                               : FIFO-read / AER handshake state encoding
package spike_fifo_reader_pkg;

  localparam int unsigned NUM_CH_DEF   = 16;
  localparam int unsigned ADDR_DW_DEF  = 14;
  localparam int unsigned STAMP_DW_DEF = 4;
  localparam int unsigned EVT_CNT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_REQ       = 3'd4,
    ST_ACK_LOW   = 3'd5
  } aer_fsm_e;

endpackage

// File: rtl/spike_fifo_reader_rr_pick.sv
// Round-robin picker: first requesting channel at or after ptr, searching upward
// modulo NUM_CH.
//   req     : per-channel request (FIFO non-empty)
//   ptr     : search start index
//   grant_c : one-hot grant (combinational)
//   idx_c   : binary index of the granted channel (combinational)
//   valid_c : a grant was found (combinational)
module rr_pick #(
  parameter int unsigned NUM_CH = 16
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [NUM_CH-1:0]         grant_c,
  output logic [$clog2(NUM_CH)-1:0] idx_c,
  output logic                      valid_c
);

  localparam int unsigned PTR_W = $clog2(NUM_CH);

  logic [PTR_W-1:0] cand;

  // Walk the rotated request vector; the first hit wins.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = PTR_W'((32'(ptr) + i) % NUM_CH);
      if (!valid_c && req[cand]) begin
        grant_c[cand] = 1'b1;
        idx_c         = cand;
        valid_c       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_fifo_reader.sv
// Drain side of the output spike FIFO bank: round-robin read of non-empty channels,
// capture of the returned address/stamp, and a four-phase AER req/ack to the router.
//   CLK, RST_N      : clock, synchronous active-low reset
//   enable          : permits new arbitration; an in-flight event always completes
//   empty_group     : per-channel FIFO empty flags
//   fifo_dout/stamp : muxed FIFO data, valid the cycle after the read strobe
//   re              : one-hot read strobe, one cycle per grant
//   aer_req/ack     : AER handshake; aer_addr/aer_stamp stable while aer_req = 1
//   busy, drained   : status (not idle / idle with every FIFO empty)
//   event_cnt       : completed events since reset, wrapping
module spike_fifo_reader
  import spike_fifo_reader_pkg::*;
#(
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  parameter int unsigned ADDR_DW  = ADDR_DW_DEF,
  parameter int unsigned STAMP_DW = STAMP_DW_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    empty_group,
  input  logic [ADDR_DW-1:0]   fifo_dout,
  input  logic [STAMP_DW-1:0]  fifo_stamp,
  output logic [NUM_CH-1:0]    re,
  output logic                 aer_req,
  input  logic                 aer_ack,
  output logic [ADDR_DW-1:0]   aer_addr,
  output logic [STAMP_DW-1:0]  aer_stamp,
  output logic                 busy,
  output logic                 drained,
  output logic [EVT_CNT_W-1:0] event_cnt
);

  localparam int unsigned PTR_W = $clog2(NUM_CH);

  aer_fsm_e             state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     gidx_q, gidx_d;
  logic [NUM_CH-1:0]    re_q, re_d;
  logic                 req_q, req_d;
  logic [ADDR_DW-1:0]   addr_q, addr_d;
  logic [STAMP_DW-1:0]  stamp_q, stamp_d;
  logic [EVT_CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_CH-1:0]    nonempty_c;
  logic [NUM_CH-1:0]    pick_grant_c;
  logic [PTR_W-1:0]     pick_idx_c;
  logic                 pick_valid_c;

  assign nonempty_c = ~empty_group;

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req     (nonempty_c),
    .ptr     (ptr_q),
    .grant_c (pick_grant_c),
    .idx_c   (pick_idx_c),
    .valid_c (pick_valid_c)
  );

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      re_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      stamp_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      re_q    <= re_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      stamp_q <= stamp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-output logic; re defaults low so it pulses only in READ.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    re_d    = '0;
    req_d   = req_q;
    addr_d  = addr_q;
    stamp_d = stamp_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && pick_valid_c) begin
          re_d    = pick_grant_c;
          gidx_d  = pick_idx_c;
          state_d = ST_READ;
        end
      end
      ST_READ:      state_d = ST_WAIT_DATA;
      ST_WAIT_DATA: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        addr_d  = fifo_dout;
        stamp_d = fifo_stamp;
        ptr_d   = (gidx_q == PTR_W'(NUM_CH - 1)) ? '0 : gidx_q + PTR_W'(1);
        req_d   = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (aer_ack) begin
          req_d   = 1'b0;
          state_d = ST_ACK_LOW;
        end
      end
      ST_ACK_LOW: begin
        // Event is complete once the receiver has released ack.
        if (!aer_ack) begin
          cnt_d   = cnt_q + EVT_CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign re        = re_q;
  assign aer_req   = req_q;
  assign aer_addr  = addr_q;
  assign aer_stamp = stamp_q;
  assign event_cnt = cnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign drained   = (state_q == ST_IDLE) && (&empty_group);

endmodule

// File: tb/tb_spike_fifo_reader.sv
// Directed testbench for spike_fifo_reader. A small FIFO-bank stand-in returns a
// fixed per-channel address/stamp the cycle after each read strobe.
module tb_spike_fifo_reader;

  localparam int unsigned NCH = 16;
  localparam int unsigned AW  = 14;
  localparam int unsigned SW  = 4;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic           enable;
  logic [NCH-1:0] empty_group;
  logic [AW-1:0]  fifo_dout;
  logic [SW-1:0]  fifo_stamp;
  logic [NCH-1:0] re;
  logic           aer_req;
  logic           aer_ack;
  logic [AW-1:0]  aer_addr;
  logic [SW-1:0]  aer_stamp;
  logic           busy;
  logic           drained;
  logic [15:0]    event_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int re_pulses = 0;

  logic [AW-1:0] dout_tab  [NCH];
  logic [SW-1:0] stamp_tab [NCH];

  spike_fifo_reader dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .enable      (enable),
    .empty_group (empty_group),
    .fifo_dout   (fifo_dout),
    .fifo_stamp  (fifo_stamp),
    .re          (re),
    .aer_req     (aer_req),
    .aer_ack     (aer_ack),
    .aer_addr    (aer_addr),
    .aer_stamp   (aer_stamp),
    .busy        (busy),
    .drained     (drained),
    .event_cnt   (event_cnt)
  );

  always #5 CLK = ~CLK;

  // FIFO bank stand-in: data for the strobed channel appears after the read edge.
  always @(posedge CLK) begin
    if (|re) begin
      for (int i = 0; i < NCH; i++) begin
        if (re[i]) begin
          fifo_dout  <= dout_tab[i];
          fifo_stamp <= stamp_tab[i];
        end
      end
      re_pulses <= re_pulses + 1;
    end
  end

  task automatic wait_re(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (|re) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (aer_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at a negedge with aer_req high; returns at a negedge back in IDLE.
  task automatic finish_hs();
    aer_ack = 1'b1;
    @(negedge CLK);
    aer_ack = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; enable = 1'b0; aer_ack = 1'b0; empty_group = '1;
    repeat (3) @(negedge CLK);
    n_checks++; if (re !== 16'h0000) begin n_fail++; $display("FAIL rst_re: got %h want 0000", re); end
    n_checks++; if (aer_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", aer_req); end
    n_checks++; if (aer_addr !== 14'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", aer_addr); end
    n_checks++; if (aer_stamp !== 4'h0) begin n_fail++; $display("FAIL rst_stamp: got %h want 0", aer_stamp); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (event_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", event_cnt); end
    n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL rst_drained: got %b want 1", drained); end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single_event();
    enable = 1'b1; empty_group = 16'hFFFE;
    @(negedge CLK);
    n_checks++; if (re !== 16'h0001) begin n_fail++; $display("FAIL se_re: got %h want 0001", re); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL se_busy: got %b want 1", busy); end
    empty_group = 16'hFFFF;
    @(negedge CLK);
    n_checks++; if (re !== 16'h0000) begin n_fail++; $display("FAIL se_re_pulse: got %h want 0000", re); end
    @(negedge CLK);
    n_checks++; if (aer_req !== 1'b0) begin n_fail++; $display("FAIL se_req_early: got %b want 0", aer_req); end
    @(negedge CLK);
    n_checks++; if (aer_req !== 1'b1) begin n_fail++; $display("FAIL se_req: got %b want 1", aer_req); end
    n_checks++; if (aer_addr !== 14'h0123) begin n_fail++; $display("FAIL se_addr: got %h want 0123", aer_addr); end
    n_checks++; if (aer_stamp !== 4'h5) begin n_fail++; $display("FAIL se_stamp: got %h want 5", aer_stamp); end
    aer_ack = 1'b1;
    @(negedge CLK);
    n_checks++; if (aer_req !== 1'b0) begin n_fail++; $display("FAIL se_req_drop: got %b want 0", aer_req); end
    aer_ack = 1'b0;
    @(negedge CLK);
    n_checks++; if (event_cnt !== 16'd1) begin n_fail++; $display("FAIL se_cnt: got %0d want 1", event_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL se_idle: got busy %b want 0", busy); end
    n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL se_drained: got %b want 1", drained); end
  endtask

  task automatic test_round_robin();
    int            exp_ch   [5] = '{3, 7, 15, 3, 7};
    logic [AW-1:0] exp_addr [5] = '{14'h233, 14'h277, 14'h2FF, 14'h233, 14'h277};
    logic [NCH-1:0] exp_re;
    bit ok;
    empty_group = 16'h7F77;
    for (int e = 0; e < 5; e++) begin
      exp_re = 16'h0001 << exp_ch[e];
      wait_re(20, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_re_timeout[%0d]: got none want %h", e, exp_re); end
      n_checks++; if (re !== exp_re) begin n_fail++; $display("FAIL rr_grant[%0d]: got %h want %h", e, re, exp_re); end
      wait_req(10, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_req_timeout[%0d]: got 0 want 1", e); end
      n_checks++; if (aer_addr !== exp_addr[e]) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h want %h", e, aer_addr, exp_addr[e]); end
      finish_hs();
    end
    n_checks++; if (event_cnt !== 16'd6) begin n_fail++; $display("FAIL rr_cnt: got %0d want 6", event_cnt); end
  endtask

  task automatic test_back_pressure();
    bit ok;
    bit stable;
    int p0;
    empty_group = 16'hFFDF;
    wait_re(20, ok);
    n_checks++; if (!ok || re !== 16'h0020) begin n_fail++; $display("FAIL bp_grant: got %h want 0020", re); end
    wait_req(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_req_timeout: got 0 want 1"); end
    p0 = re_pulses;
    stable = 1'b1;
    repeat (50) begin
      @(negedge CLK);
      if (aer_req !== 1'b1 || aer_addr !== 14'h255 || aer_stamp !== 4'h5) stable = 1'b0;
    end
    n_checks++; if (!stable) begin n_fail++; $display("FAIL bp_stable: got req %b addr %h stamp %h want 1/255/5", aer_req, aer_addr, aer_stamp); end
    n_checks++; if (re_pulses !== p0) begin n_fail++; $display("FAIL bp_no_re: got %0d pulses want %0d", re_pulses, p0); end
    n_checks++; if (event_cnt !== 16'd6) begin n_fail++; $display("FAIL bp_cnt_hold: got %0d want 6", event_cnt); end
    finish_hs();
    empty_group = 16'hFFFF;
    n_checks++; if (event_cnt !== 16'd7) begin n_fail++; $display("FAIL bp_cnt: got %0d want 7", event_cnt); end
  endtask

  task automatic test_enable_gating();
    bit ok;
    int p0;
    enable = 1'b0; empty_group = 16'h0000;
    p0 = re_pulses;
    repeat (5) @(negedge CLK);
    n_checks++; if (re_pulses !== p0) begin n_fail++; $display("FAIL en_no_re: got %0d pulses want %0d", re_pulses, p0); end
    n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL en_drained: got %b want 0", drained); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_busy: got %b want 0", busy); end
    enable = 1'b1;
    wait_re(5, ok);
    n_checks++; if (!ok || re !== 16'h0040) begin n_fail++; $display("FAIL en_grant: got %h want 0040", re); end
    wait_req(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL en_req_timeout: got 0 want 1"); end
    enable = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++; if (aer_req !== 1'b1) begin n_fail++; $display("FAIL en_req_hold: got %b want 1", aer_req); end
    finish_hs();
    n_checks++; if (event_cnt !== 16'd8) begin n_fail++; $display("FAIL en_cnt: got %0d want 8", event_cnt); end
    p0 = re_pulses;
    repeat (5) @(negedge CLK);
    n_checks++; if (re_pulses !== p0) begin n_fail++; $display("FAIL en_idle_re: got %0d pulses want %0d", re_pulses, p0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_idle: got busy %b want 0", busy); end
    n_checks++; if (aer_addr !== 14'h266) begin n_fail++; $display("FAIL en_addr: got %h want 266", aer_addr); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    enable = 1'b1;
    wait_re(5, ok);
    n_checks++; if (!ok || re !== 16'h0080) begin n_fail++; $display("FAIL rm_grant: got %h want 0080", re); end
    wait_req(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rm_req_timeout: got 0 want 1"); end
    RST_N = 1'b0;
    @(negedge CLK);
    n_checks++; if (aer_req !== 1'b0) begin n_fail++; $display("FAIL rm_req: got %b want 0", aer_req); end
    n_checks++; if (event_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_cnt: got %0d want 0", event_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_checks++; if (aer_addr !== 14'h0) begin n_fail++; $display("FAIL rm_addr: got %h want 0", aer_addr); end
    // ptr back at 0 means channel 3 wins over 7 and 15.
    empty_group = 16'h7F77;
    RST_N = 1'b1;
    wait_re(5, ok);
    n_checks++; if (!ok || re !== 16'h0008) begin n_fail++; $display("FAIL rm_ptr: got %h want 0008", re); end
    wait_req(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rm_req_timeout2: got 0 want 1"); end
    empty_group = 16'hFFFF;
    finish_hs();
    n_checks++; if (event_cnt !== 16'd1) begin n_fail++; $display("FAIL rm_cnt2: got %0d want 1", event_cnt); end
  endtask

  task automatic test_counter_wrap();
    bit ok;
    empty_group = 16'hFFFF;
    force dut.cnt_q = 16'hFFFF;
    @(negedge CLK);
    release dut.cnt_q;
    @(negedge CLK);
    n_checks++; if (event_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cw_preload: got %h want FFFF", event_cnt); end
    empty_group = 16'hFFEF;
    wait_re(5, ok);
    n_checks++; if (!ok || re !== 16'h0010) begin n_fail++; $display("FAIL cw_grant: got %h want 0010", re); end
    empty_group = 16'hFFFF;
    wait_req(10, ok);
    n_checks++; if (!ok || aer_addr !== 14'h244) begin n_fail++; $display("FAIL cw_addr: got %h want 244", aer_addr); end
    finish_hs();
    n_checks++; if (event_cnt !== 16'h0000) begin n_fail++; $display("FAIL cw_wrap: got %h want 0000", event_cnt); end
    n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL cw_drained: got %b want 1", drained); end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      dout_tab[i]  = AW'(32'h200 + 32'(i) * 17);
      stamp_tab[i] = SW'(i);
    end
    dout_tab[0]  = 14'h0123;
    stamp_tab[0] = 4'h5;
    test_reset();
    test_single_event();
    test_round_robin();
    test_back_pressure();
    test_enable_gating();
    test_reset_mid();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
